// File: rtl/sys_array_ctrl_if.sv
// ============================================================================
// sys_array_ctrl_if : host/DMA and array-side bundle for sys_array_ctrl
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface sys_array_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_N    = 4,
  parameter int CNT_W      = 8
);
  logic                            start;
  logic [CNT_W-1:0]                num_vec;
  logic                            busy;
  logic                            done;
  logic                            in_valid;
  logic                            in_ready;
  logic [ARRAY_N*DATA_WIDTH-1:0]   in_data;
  logic                            arr_weights_load;
  logic [ARRAY_N*DATA_WIDTH-1:0]   arr_input_data;
  logic [ARRAY_N*2*DATA_WIDTH-1:0] arr_output_data;
  logic                            out_valid;
  logic [ARRAY_N*2*DATA_WIDTH-1:0] out_data;
  logic [31:0]                     perf_busy_cycles;
  logic [31:0]                     perf_stall_cycles;

  modport slave (
    input  start, num_vec, in_valid, in_data, arr_output_data,
    output busy, done, in_ready, arr_weights_load, arr_input_data,
           out_valid, out_data, perf_busy_cycles, perf_stall_cycles
  );

  modport master (
    output start, num_vec, in_valid, in_data, arr_output_data,
    input  busy, done, in_ready, arr_weights_load, arr_input_data,
           out_valid, out_data, perf_busy_cycles, perf_stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/sys_array_ctrl.sv
// ============================================================================
// sys_array_ctrl : job sequencer, input skew and output deskew for the
// weight-stationary systolic array. Optional counters: SYS_ARRAY_CTRL_PERF_EN
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_array_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_N    = 4,
  parameter int ARRAY_LAT  = 4,
  parameter int WLOAD_CYC  = 1,
  parameter int CNT_W      = 8
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  sys_array_ctrl_if.slave   bus
);

  localparam int DW   = DATA_WIDTH;
  localparam int RW   = 2 * DATA_WIDTH;
  localparam int VLEN = ARRAY_LAT + ARRAY_N;
  localparam logic [3:0] C_WL_LAST = 4'(WLOAD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WLOAD  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] acc_q;
  logic [3:0]       wcnt_q;
  logic             busy_q;
  logic             done_q;
  logic             in_ready_q;
  logic             wl_q;
  logic [VLEN-1:0]  v_q;
  logic             out_valid_q;

  logic             w_accept;
  logic [CNT_W-1:0] w_acc_nxt;

  assign w_accept  = bus.in_valid & in_ready_q;
  assign w_acc_nxt = acc_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      acc_q      <= '0;
      wcnt_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      wl_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            num_q  <= bus.num_vec;
            acc_q  <= '0;
            busy_q <= 1'b1;
            if (bus.num_vec == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WLOAD;
              wl_q    <= 1'b1;
              wcnt_q  <= '0;
            end
          end
        end
        S_WLOAD: begin
          if (wcnt_q == C_WL_LAST) begin
            wl_q       <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= S_STREAM;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        S_STREAM: begin
          if (w_accept) begin
            acc_q <= w_acc_nxt;
            if (w_acc_nxt == num_q) begin
              in_ready_q <= 1'b0;
              state_q    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Empty pipe means the final token sits in out_valid this cycle
          if (v_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      v_q         <= {v_q[VLEN-2:0], w_accept};
      out_valid_q <= v_q[VLEN-1];
    end
  end

  // Lane k: entry register plus k further stages; bubbles inject zero
  for (genvar k = 0; k < ARRAY_N; k++) begin : g_skew
    logic [DW-1:0] sk_q [k+1];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int j = 0; j <= k; j++) sk_q[j] <= '0;
      end else begin
        sk_q[0] <= w_accept ? bus.in_data[k*DW +: DW] : '0;
        for (int j = 1; j <= k; j++) sk_q[j] <= sk_q[j-1];
      end
    end
    assign bus.arr_input_data[k*DW +: DW] = sk_q[k];
  end

  // Lane k: (ARRAY_N-1-k) alignment stages, the last stage is the output register
  for (genvar k = 0; k < ARRAY_N; k++) begin : g_deskew
    localparam int D = ARRAY_N - k;
    logic [RW-1:0] dk_q [D];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int j = 0; j < D; j++) dk_q[j] <= '0;
      end else begin
        dk_q[0] <= bus.arr_output_data[k*RW +: RW];
        for (int j = 1; j < D; j++) dk_q[j] <= dk_q[j-1];
      end
    end
    assign bus.out_data[k*RW +: RW] = dk_q[D-1];
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.in_ready         = in_ready_q;
  assign bus.arr_weights_load = wl_q;
  assign bus.out_valid        = out_valid_q;

`ifdef SYS_ARRAY_CTRL_PERF_EN
  logic [31:0] pbusy_q;
  logic [31:0] pstall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pbusy_q  <= '0;
      pstall_q <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      pbusy_q  <= '0;
      pstall_q <= '0;
    end else begin
      if (busy_q && !(&pbusy_q))
        pbusy_q <= pbusy_q + 1'b1;
      if (state_q == S_STREAM && in_ready_q && !bus.in_valid && !(&pstall_q))
        pstall_q <= pstall_q + 1'b1;
    end
  end

  assign bus.perf_busy_cycles  = pbusy_q;
  assign bus.perf_stall_cycles = pstall_q;
`else
  assign bus.perf_busy_cycles  = '0;
  assign bus.perf_stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sys_array_ctrl.sv
// ============================================================================
// tb_sys_array_ctrl : scoreboard bench for sys_array_ctrl with an identity
// array model (pure LAT-cycle delay, sign-extended)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sys_array_ctrl;

  localparam int DW  = 8;
  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int CW  = 8;
  localparam int VW  = N * DW;
  localparam int RW  = N * 2 * DW;
  localparam int OUT_DLY = LAT + N + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sys_array_ctrl_if #(.DATA_WIDTH(DW), .ARRAY_N(N), .CNT_W(CW)) bus ();
  sys_array_ctrl_if #(.DATA_WIDTH(DW), .ARRAY_N(N), .CNT_W(CW)) bus3 ();

  sys_array_ctrl #(.DATA_WIDTH(DW), .ARRAY_N(N), .ARRAY_LAT(LAT),
                   .WLOAD_CYC(1), .CNT_W(CW))
    u_dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  sys_array_ctrl #(.DATA_WIDTH(DW), .ARRAY_N(N), .ARRAY_LAT(LAT),
                   .WLOAD_CYC(3), .CNT_W(CW))
    u_dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] sext(input logic [VW-1:0] v);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      r[k*2*DW +: 2*DW] = {{DW{v[k*DW+DW-1]}}, v[k*DW +: DW]};
    return r;
  endfunction

  // Identity-weight array: each lane appears LAT cycles later, sign-extended
  logic [VW-1:0] arr_d [LAT];
  always_ff @(posedge clk) begin
    arr_d[0] <= bus.arr_input_data;
    for (int j = 1; j < LAT; j++) arr_d[j] <= arr_d[j-1];
  end
  assign bus.arr_output_data  = sext(arr_d[LAT-1]);
  assign bus3.arr_output_data = '0;

  typedef struct {
    logic [RW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  int busy_cnt, wl_cnt, rdy_cnt, done_cnt, ov_cnt;
  int done_cyc, last_ov_cyc, st_cyc;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.busy)             busy_cnt++;
      if (bus.arr_weights_load) wl_cnt++;
      if (bus.in_ready)         rdy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back('{data: sext(bus.in_data), cyc: cyc + OUT_DLY});
      if (bus.out_valid) begin
        ov_cnt++;
        last_ov_cyc = cyc;
        chk("ov_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_cycle", cyc, e.cyc);
        end
      end
    end
  end

  int wl3_cnt = 0, last_wl3 = -1, first_rdy3 = -1, ov3_cnt = 0, done3_cnt = 0, done3_cyc = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus3.arr_weights_load) begin
        wl3_cnt++;
        last_wl3 = cyc;
      end
      if (bus3.in_ready && first_rdy3 < 0) first_rdy3 = cyc;
      if (bus3.out_valid) ov3_cnt++;
      if (bus3.done) begin
        done3_cnt++;
        done3_cyc = cyc;
      end
    end
  end

  logic [VW-1:0] in_q[$];

  task automatic clear_stats();
    busy_cnt = 0; wl_cnt = 0; rdy_cnt = 0; done_cnt = 0; ov_cnt = 0;
    done_cyc = -1; last_ov_cyc = -1;
  endtask

  task automatic start_job(input logic [CW-1:0] n);
    bus.start   = 1'b1;
    bus.num_vec = n;
    st_cyc      = cyc + 1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
  endtask

  task automatic feed(input logic [31:0] pat, input int npat);
    int   idx = 0;
    int   guard = 0;
    logic acc;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("in_ready_rise", bus.in_ready, 1);
    while (in_q.size() > 0 && guard < 300) begin
      bus.in_valid = (npat == 0 || idx >= npat) ? 1'b1 : pat[idx];
      bus.in_data  = in_q[0];
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) void'(in_q.pop_front());
      idx++;
      guard++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (done_cnt == 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("done_seen", done_cnt, 1);
  endtask

  task automatic pulse_start_ignored();
    int g = 0;
    while (!bus.in_ready && g < 100) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_vec = 8'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (bus.in_ready && g < 200) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.start = 0; bus.num_vec = '0; bus.in_valid = 0; bus.in_data = '0;
    bus3.start = 0; bus3.num_vec = '0; bus3.in_valid = 0; bus3.in_data = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wload", bus.arr_weights_load, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_arr_in", bus.arr_input_data, 0);
    chk("rst_perf_busy", bus.perf_busy_cycles, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single job, continuous valid
    clear_stats();
    in_q = '{32'h04030201, 32'h08070605, 32'hFCFDFEFF};
    start_job(3);
    feed(32'h0, 0);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    chk("t1_wload_cycles", wl_cnt, 1);
    chk("t1_out_count", ov_cnt, 3);
    chk("t1_done_after_last", done_cyc, last_ov_cyc + 1);
    chk("t1_busy_low", bus.busy, 0);
    chk("t1_sb_empty", sb.size(), 0);
`ifdef SYS_ARRAY_CTRL_PERF_EN
    chk("t1_perf_busy", bus.perf_busy_cycles, done_cyc - st_cyc + 1);
`else
    chk("t1_perf_busy", bus.perf_busy_cycles, 0);
`endif

    // Bubbles: valid pattern 1,0,0,1,1,0,1
    clear_stats();
    in_q = '{32'h11223344, 32'h80FF7F01, 32'h0A0B0C0D, 32'hDEADBEEF};
    start_job(4);
    feed(32'h59, 7);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    chk("t2_out_count", ov_cnt, 4);
    chk("t2_sb_empty", sb.size(), 0);
`ifdef SYS_ARRAY_CTRL_PERF_EN
    chk("t2_perf_stall", bus.perf_stall_cycles, 3);
`else
    chk("t2_perf_stall", bus.perf_stall_cycles, 0);
`endif

    // num_vec = 0
    clear_stats();
    start_job(0);
    chk("t3_done_now", bus.done, 1);
    chk("t3_busy_now", bus.busy, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_busy_cycles", busy_cnt, 1);
    chk("t3_no_wload", wl_cnt, 0);
    chk("t3_no_ready", rdy_cnt, 0);
    chk("t3_done_count", done_cnt, 1);
    chk("t3_done_cycle", done_cyc, st_cyc);

    // start pulses during STREAM and DRAIN are ignored
    clear_stats();
    in_q = '{32'h01010101, 32'hF0F1F2F3, 32'h7F807F80, 32'h00000001};
    start_job(4);
    fork
      feed(32'h59, 7);
      pulse_start_ignored();
    join
    wait_done();
    repeat (15) @(posedge clk);
    #1;
    chk("t4_out_count", ov_cnt, 4);
    chk("t4_done_count", done_cnt, 1);
    chk("t4_wload_cycles", wl_cnt, 1);
    chk("t4_busy_low", bus.busy, 0);

    // Reset after 2 of 4 accepted
    clear_stats();
    in_q = '{32'h12345678, 32'h9ABCDEF0};
    start_job(4);
    feed(32'h0, 0);
    reset_n = 1'b0;
    #1;
    chk("t5_busy", bus.busy, 0);
    chk("t5_in_ready", bus.in_ready, 0);
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_arr_in", bus.arr_input_data, 0);
    chk("t5_out_data", bus.out_data, 0);
    sb.delete();
    clear_stats();
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_ov", ov_cnt, 0);
    chk("t5_no_done", done_cnt, 0);
    in_q = '{32'h80818283};
    start_job(1);
    feed(32'h0, 0);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    chk("t5_new_out_count", ov_cnt, 1);
    chk("t5_new_sb_empty", sb.size(), 0);

    // WLOAD_CYC = 3 instance, num_vec = 1
    bus3.in_valid = 1'b1;
    bus3.in_data  = 32'h55AA55AA;
    bus3.start    = 1'b1;
    bus3.num_vec  = 8'd1;
    st_cyc        = cyc + 1;
    @(posedge clk); #1;
    bus3.start = 1'b0;
    begin
      int g = 0;
      while (done3_cnt == 0 && g < 200) begin @(posedge clk); #1; g++; end
    end
    bus3.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_done_count", done3_cnt, 1);
    chk("t6_wload_cycles", wl3_cnt, 3);
    chk("t6_ready_after_wload", first_rdy3, last_wl3 + 1);
    chk("t6_out_count", ov3_cnt, 1);
`ifdef SYS_ARRAY_CTRL_PERF_EN
    chk("t6_perf_busy", bus3.perf_busy_cycles, done3_cyc - st_cyc + 1);
`else
    chk("t6_perf_busy", bus3.perf_busy_cycles, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sys_array_ctrl.md
Name: sys_array_ctrl

Overview:
Sequencer for the weight-stationary systolic array. Per job it loads the weights, accepts a stream of input vectors over a valid/ready handshake and applies the diagonal input skew. It then realigns the array's column outputs and presents one result vector per accepted input. Sits between the host/DMA side and the array instance.

Parameters:
DATA_WIDTH, 8, input/weight element width; results are 2*DATA_WIDTH.
ARRAY_N, 4, array dimension (lanes in and out).
ARRAY_LAT, 4, array cycles from lane-0 skewed input to lane-0 column output valid.
WLOAD_CYC, 1, cycles arr_weights_load is held high (1..15).
CNT_W, 8, width of the vector count.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  job start pulse; sampled only in IDLE
num_vec  in  CNT_W  vectors in the job; latched at start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at job end
in_valid  in  1  input vector valid
in_ready  out  1  controller accepts the vector this cycle
in_data  in  ARRAY_N*DATA_WIDTH  input vector; lane k = bits [k*DW +: DW]
arr_weights_load  out  1  to the array weight-load enable
arr_input_data  out  ARRAY_N*DATA_WIDTH  skewed lanes to the array
arr_output_data  in  ARRAY_N*2*DATA_WIDTH  array column outputs
out_valid  out  1  result vector valid, single-cycle per vector; no backpressure
out_data  out  ARRAY_N*2*DATA_WIDTH  realigned result vector
perf_busy_cycles  out  32  busy-cycle counter (see Optional Feature)
perf_stall_cycles  out  32  STREAM cycles with in_valid low (see Optional Feature)

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: every output is 0. FSM returns to IDLE. Skew, deskew and valid-tracking registers clear, and counters clear.
- States and transitions:
  - IDLE: start=1 and num_vec>0 goes to WLOAD. start=1 and num_vec=0 goes to DONE, with no weight load.
  - WLOAD: arr_weights_load=1 for exactly WLOAD_CYC cycles, then STREAM.
  - STREAM: in_ready=1 while accepted<num_vec. Acceptance is in_valid & in_ready. After the last acceptance go to DRAIN; in_ready drops the cycle after the last accept.
  - DRAIN: wait until the valid-tracking pipe is empty, i.e. the last out_valid has been issued, then go to DONE.
  - DONE: done=1 for one cycle, busy still 1, then IDLE.
- start in any non-IDLE state is ignored.
- Input skew: the accepted vector is registered, and lane k is then delayed by a further k cycles before arr_input_data.
- Bubbles: in a cycle without acceptance, zero enters the skew pipe and no valid token is generated.
- Deskew: arr_output_data lane k is delayed (ARRAY_N-1-k) cycles, then a final output register.
- Latency: a vector accepted on edge t gives out_valid high in cycle t+ARRAY_LAT+ARRAY_N. Results are in acceptance order, one out_valid per accepted vector. Back-to-back accepts give back-to-back out_valid.
- out_data is don't-care when out_valid=0. The bench compares only on out_valid.
- Arithmetic: no computation in the controller. Lanes pass bit-exact; signedness is preserved.
- Reset mid-job: immediate abort to IDLE. No done pulse and no further out_valid.

Optional Feature:
SYS_ARRAY_CTRL_PERF_EN.
- Defined:
  - perf_busy_cycles increments on every cycle busy=1.
  - perf_stall_cycles increments on STREAM cycles where in_ready=1 and in_valid=0.
  - Both clear when a job starts (IDLE exit), saturate at all-ones, and hold after done.
- Undefined: both ports are driven constant 0 and no counter logic is built.

Test Plan:
- Single job, ARRAY_N=4, identity weights, num_vec=3, in_valid held high with vectors {1,2,3,4},{5,6,7,8},{-1,-2,-3,-4} -> arr_weights_load high 1 cycle; 3 consecutive out_valid starting 8 cycles after the first accept; out_data equals the inputs sign-extended; done 1 cycle after DRAIN; busy low after.
- Bubbles: num_vec=4, in_valid pattern 1,0,0,1,1,0,1 -> four out_valid pulses with the same gaps shifted by 8 cycles, in order. With the macro, perf_stall_cycles=3.
- num_vec=0 start -> no arr_weights_load, no in_ready; done pulse on the 2nd cycle after start; busy high exactly 1 cycle.
- start pulsed during STREAM and again during DRAIN -> ignored; exactly num_vec outputs and one done.
- reset_n low for 1 cycle after 2 of 4 vectors accepted -> all outputs 0 at once, no later out_valid/done. A new job with num_vec=1 then runs normally.
- WLOAD_CYC=3, num_vec=1 -> arr_weights_load high 3 cycles; in_ready rises the cycle after it falls. With the macro, perf_busy_cycles matches the cycle count from the start edge to done inclusive.
